ram_burst_ctrl: RTL



---
 rtl/ram_burst_pkg.sv | 21 ++
 rtl/ram_burst_rdbuf.sv | 55 +++++
 rtl/ram_burst_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst controller: state encoding,
// default geometry and the read-buffer depth derivation.
package ram_burst_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 16;
    localparam int LEN_W_DEF  = 8;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Read buffer must absorb every address in flight plus one beat of slack
    function automatic int rdbuf_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/ram_burst_rdbuf.sv
// Read-data buffer for the burst controller: DEPTH x DW synchronous FIFO.
// Push and pop may coincide; occupancy is exported for credit accounting.
module ram_burst_rdbuf #(
    parameter int  DW    = 16,
    parameter int  DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] occupancy,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == CW'(DEPTH));
    assign head_data = mem[rptr];

    // Pointer and occupancy tracking; simultaneous push/pop keeps occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            assert (!(push && !pop && full));
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Data storage, written at the tail
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Initiator-side burst controller for a single-port synchronous RAM.
// One read or write burst at a time; reads are credit-limited so the
// read buffer cannot overflow despite RD_LAT cycles of RAM latency.
// Optional: define MEM_SEQ_WRAP_ERR_EN to reject bursts that would wrap
// past the top of the address space (err+done pulse, no RAM access).
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    localparam int DEPTH = rdbuf_depth(RD_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = LEN_W + 1;

    state_t            state;
    logic [AW-1:0]     addr;        // next address to write or issue
    logic [RW-1:0]     left;        // beats still to write / deliver
    logic [RW-1:0]     iss_left;    // read addresses still to issue
    logic              iss_vld_p0;  // ram_addr carries a live read this cycle
    logic [RD_LAT-1:0] cap_vld_sr;  // read data arrival tracking
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     occupancy;
    logic [DW-1:0]     head_data;
    logic              empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic              rd_start;
    logic [CW:0]       credit_use;

`ifdef MEM_SEQ_WRAP_ERR_EN
    logic wrap_bad;
    assign wrap_bad = ({1'b0, cmd_addr} + (AW+1)'(cmd_len)) > {1'b0, {AW{1'b1}}};
`endif

    assign push     = cap_vld_sr[RD_LAT-1];
    assign rd_valid = (state == READ) && !empty;
    assign rd_data  = rd_valid ? head_data : '0;
    assign pop      = rd_valid && rd_ready;

    // Read issue decision: credits cover addresses in flight plus buffered beats
    always_comb begin
        credit_use = {1'b0, inflight} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
        issue      = (state == READ) && (iss_left != '0) && (credit_use < (CW+1)'(DEPTH));
        rd_start   = (state == IDLE) && cmd_valid && !cmd_write;
`ifdef MEM_SEQ_WRAP_ERR_EN
        if (wrap_bad) rd_start = 1'b0;
`endif
    end

`ifndef MEM_SEQ_WRAP_ERR_EN
    assign err = 1'b0;
`endif

    // Burst FSM with registered handshake, status and RAM-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            addr       <= '0;
            left       <= '0;
            iss_left   <= '0;
            iss_vld_p0 <= 1'b0;
`ifdef MEM_SEQ_WRAP_ERR_EN
            err        <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            ram_we     <= 1'b0;
            iss_vld_p0 <= 1'b0;
`ifdef MEM_SEQ_WRAP_ERR_EN
            err        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
`ifdef MEM_SEQ_WRAP_ERR_EN
                        if (wrap_bad) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else
`endif
                        begin
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            left      <= {1'b0, cmd_len} + RW'(1);
                            if (cmd_write) begin
                                state    <= WRITE;
                                wr_ready <= 1'b1;
                                addr     <= cmd_addr;
                            end else begin
                                // first read address goes out right away
                                state      <= READ;
                                ram_addr   <= cmd_addr;
                                iss_vld_p0 <= 1'b1;
                                addr       <= cmd_addr + AW'(1);
                                iss_left   <= {1'b0, cmd_len};
                            end
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        ram_we   <= 1'b1;
                        ram_addr <= addr;
                        ram_din  <= wr_data;
                        addr     <= addr + AW'(1);
                        left     <= left - RW'(1);
                        if (left == RW'(1)) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        ram_addr   <= addr;
                        iss_vld_p0 <= 1'b1;
                        addr       <= addr + AW'(1);
                        iss_left   <= iss_left - RW'(1);
                    end
                    if (pop) begin
                        left <= left - RW'(1);
                        if (left == RW'(1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrival pipeline and in-flight credit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld_sr <= '0;
            inflight   <= '0;
        end else begin
            cap_vld_sr[0] <= iss_vld_p0;
            for (int i = 1; i < RD_LAT; i++) cap_vld_sr[i] <= cap_vld_sr[i-1];
            case ({issue | rd_start, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    ram_burst_rdbuf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rdbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (ram_dout),
        .pop       (pop),
        .head_data (head_data),
        .occupancy (occupancy),
        .empty     (empty)
    );

endmodule
